// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID boundary buffer.
// A DEPTH-entry FIFO of {pc_plus4, instruction} pairs feeds a registered
// output stage that presents entries to decode. Fetch keeps pushing while
// decode stalls, so the queue absorbs stalls without freezing fetch.
// A flush (taken branch/jump) discards everything in a single cycle.
module if_id_queue #(
    parameter int                 DATA_W    = 32,
    parameter int                 PC_W      = 32,
    parameter int                 DEPTH     = 4,
    parameter logic [DATA_W-1:0]  NOP_INSTR = {DATA_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            pc_plus4_in,
    input  logic [DATA_W-1:0]          instruction_in,
    input  logic                       hazard_in,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          instruction_out,
    output logic [PC_W-1:0]            pc_plus4_out,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Queue storage; contents are only meaningful where count says so,
    // so it is never cleared.
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem    [DEPTH];

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  count;

    logic push_req;
    logic adv;
    logic queue_empty;
    logic pop;
    logic bypass;
    logic push;

    // in_ready depends only on the registered count so fetch never sees a
    // combinational path from decode-side stall or flush.
    assign in_ready    = (count < DEPTH_CNT);
    assign push_req    = in_valid & in_ready;
    assign adv         = ~hazard_in & ~flush;
    assign queue_empty = (count == '0);

    // The output stage takes the queue head first; only when the queue is
    // empty can a fresh fetch skip straight to the output stage.
    assign pop    = adv & ~queue_empty;
    assign bypass = adv & queue_empty & push_req;

    // An entry accepted in a flush cycle is dropped along with the queue.
    assign push   = push_req & ~bypass & ~flush;

    assign fifo_count = count;

    // Occupancy and pointers; full/empty decisions come from count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue write port.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= instruction_in;
            pc_mem[wr_ptr]    <= pc_plus4_in;
        end
    end

    // Output stage: bubble on flush, hold on stall, otherwise load the
    // queue head, the bypassed input, or a bubble in that order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            instruction_out <= NOP_INSTR;
            pc_plus4_out    <= '0;
        end else if (flush) begin
            out_valid       <= 1'b0;
            instruction_out <= NOP_INSTR;
            pc_plus4_out    <= '0;
        end else if (adv) begin
            if (pop) begin
                out_valid       <= 1'b1;
                instruction_out <= instr_mem[rd_ptr];
                pc_plus4_out    <= pc_mem[rd_ptr];
            end else if (bypass) begin
                out_valid       <= 1'b1;
                instruction_out <= instruction_in;
                pc_plus4_out    <= pc_plus4_in;
            end else begin
                out_valid       <= 1'b0;
                instruction_out <= NOP_INSTR;
                pc_plus4_out    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the IF/ID buffer.
module tb_if_id_queue #(
    parameter int DEPTH = 4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       pc_plus4_in;
    logic [31:0]       instruction_in;
    logic              hazard_in;
    logic              flush;
    logic              out_valid;
    logic [31:0]       instruction_out;
    logic [31:0]       pc_plus4_out;
    logic [CNT_W-1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: a queue of {pc, instr} plus the output stage.
    logic [63:0] m_q [$];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc    = 32'h0;
    logic        m_accept;
    logic [63:0] m_head;

    if_id_queue #(
        .DATA_W    (32),
        .PC_W      (32),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pc_plus4_in     (pc_plus4_in),
        .instruction_in  (instruction_in),
        .hazard_in       (hazard_in),
        .flush           (flush),
        .out_valid       (out_valid),
        .instruction_out (instruction_out),
        .pc_plus4_out    (pc_plus4_out),
        .fifo_count      (fifo_count)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input int k);
        return 32'h1000_0000 + k;
    endfunction

    function automatic logic [31:0] pc_of(input int k);
        return 32'(4 * (k + 1));
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of fetch/decode inputs, then step past the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] ins, input logic hz,
                                 input logic fl);
        in_valid       = v;
        pc_plus4_in    = pc;
        instruction_in = ins;
        hazard_in      = hz;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    // Reference model: advances once per clock using the rules of the
    // buffer expressed as plain queue operations.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_valid = 1'b0;
                m_instr = NOP;
                m_pc    = 32'h0;
            end else begin
                m_accept = in_valid && (m_q.size() < DEPTH);
                if (flush) begin
                    m_q.delete();
                    m_valid = 1'b0;
                    m_instr = NOP;
                    m_pc    = 32'h0;
                end else if (!hazard_in) begin
                    if (m_q.size() > 0) begin
                        m_head  = m_q.pop_front();
                        m_valid = 1'b1;
                        m_pc    = m_head[63:32];
                        m_instr = m_head[31:0];
                        if (m_accept) m_q.push_back({pc_plus4_in, instruction_in});
                    end else if (m_accept) begin
                        m_valid = 1'b1;
                        m_pc    = pc_plus4_in;
                        m_instr = instruction_in;
                    end else begin
                        m_valid = 1'b0;
                        m_instr = NOP;
                        m_pc    = 32'h0;
                    end
                end else if (m_accept) begin
                    m_q.push_back({pc_plus4_in, instruction_in});
                end
            end
        end
    end

    // Every cycle, away from the active edge, compare DUT against model.
    always @(negedge clk) begin
        checkOutput("model out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("model instruction_out", 64'(instruction_out), 64'(m_instr));
        checkOutput("model pc_plus4_out", 64'(pc_plus4_out), 64'(m_pc));
        checkOutput("model fifo_count", 64'(fifo_count), 64'(m_q.size()));
        checkOutput("model in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int idx;
        int exp_cnt;
        int level;
        logic v;
        logic rdy;

        reset          = 1'b1;
        in_valid       = 1'b0;
        pc_plus4_in    = '0;
        instruction_in = '0;
        hazard_in      = 1'b0;
        flush          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset instruction_out", 64'(instruction_out), 64'(NOP));
        checkOutput("reset pc_plus4_out", 64'(pc_plus4_out), 64'(0));
        checkOutput("reset fifo_count", 64'(fifo_count), 64'(0));
        checkOutput("reset in_ready", 64'(in_ready), 64'(1));
        reset = 1'b0;

        // Bypass: empty and not stalled, one-cycle latency.
        applyStimulus(1'b1, 32'h4, 32'h2008_0005, 1'b0, 1'b0);
        checkOutput("bypass out_valid", 64'(out_valid), 64'(1));
        checkOutput("bypass instruction_out", 64'(instruction_out), 64'(32'h2008_0005));
        checkOutput("bypass pc_plus4_out", 64'(pc_plus4_out), 64'(32'h4));
        checkOutput("bypass fifo_count", 64'(fifo_count), 64'(0));

        // Stall for six cycles while fetch offers I1..I6.
        idx = 1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            applyStimulus(1'b1, pc_of(idx), instr_of(idx), 1'b1, 1'b0);
            exp_cnt = min_int(cyc, DEPTH);
            checkOutput("stall hold instruction", 64'(instruction_out), 64'(32'h2008_0005));
            checkOutput("stall hold out_valid", 64'(out_valid), 64'(1));
            checkOutput("stall fifo_count", 64'(fifo_count), 64'(exp_cnt));
            checkOutput("stall in_ready", 64'(in_ready), 64'(exp_cnt < DEPTH));
            if (cyc <= DEPTH) idx++;
        end

        // Release: I1..I6 emerge in order, fetch holds until accepted.
        for (int e = 1; e <= 6; e++) begin
            v   = (idx <= 6);
            rdy = in_ready;
            applyStimulus(v, pc_of(idx), instr_of(idx), 1'b0, 1'b0);
            if (v && rdy) idx++;
            checkOutput("release order", 64'(instruction_out), 64'(instr_of(e)));
            checkOutput("release pc", 64'(pc_plus4_out), 64'(pc_of(e)));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("drained out_valid", 64'(out_valid), 64'(0));

        // Flush dominates stall and an offered entry.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, pc_of(20 + k), instr_of(20 + k), 1'b1, 1'b0);
        end
        checkOutput("pre-flush fifo_count", 64'(fifo_count), 64'(min_int(3, DEPTH)));
        applyStimulus(1'b1, 32'hCAFE_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        checkOutput("flush fifo_count", 64'(fifo_count), 64'(0));
        checkOutput("flush out_valid", 64'(out_valid), 64'(0));
        checkOutput("flush instruction_out", 64'(instruction_out), 64'(NOP));
        checkOutput("flush pc_plus4_out", 64'(pc_plus4_out), 64'(0));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("post-flush out_valid", 64'(out_valid), 64'(0));

        // Steady push+pop at a fixed level; pointers wrap around.
        level = min_int(2, DEPTH - 1);
        for (int k = 0; k < level; k++) begin
            applyStimulus(1'b1, pc_of(40 + k), instr_of(40 + k), 1'b1, 1'b0);
        end
        for (int k = 0; k < 2 * DEPTH; k++) begin
            applyStimulus(1'b1, pc_of(40 + level + k), instr_of(40 + level + k), 1'b0, 1'b0);
            checkOutput("steady fifo_count", 64'(fifo_count), 64'(level));
            checkOutput("steady order", 64'(instruction_out), 64'(instr_of(40 + k)));
        end

        // Asynchronous reset mid-traffic, observed without a clock edge.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, pc_of(60 + k), instr_of(60 + k), 1'b1, 1'b0);
        end
        reset = 1'b1;
        #2;
        checkOutput("async reset fifo_count", 64'(fifo_count), 64'(0));
        checkOutput("async reset out_valid", 64'(out_valid), 64'(0));
        checkOutput("async reset instruction_out", 64'(instruction_out), 64'(NOP));
        checkOutput("async reset in_ready", 64'(in_ready), 64'(1));
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
